// File: rtl/conv_pkg.sv
// Shared types and helpers for the 2D convolution stream engine and the
// downstream max-pool stage.
//   conv_state_e : control FSM states of the convolution engine
//   out_dim      : valid-mode output side length for image N, kernel K, stride S
//   acc_width    : accumulator width that holds a full KxK dot product exactly
//   sat_relu     : optional ReLU followed by clamp/extend to an output width
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } conv_state_e;

  // Working width of sat_relu; accumulators and output words must stay below it.
  localparam int SAT_W = 64;

  function automatic int out_dim(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

  function automatic int acc_width(input int dw, input int k, input int is_signed);
    return 2 * dw + $clog2(k * k) + is_signed;
  endfunction

  // value arrives already sign- or zero-extended to SAT_W bits. The caller keeps
  // the low ow bits of the return value; when ow exceeds the accumulator width
  // no clamp fires and those bits are the extended result.
  function automatic logic [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] value,
                                                input int ow,
                                                input bit is_signed,
                                                input bit relu);
    logic signed [SAT_W-1:0] x;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    x = value;
    if (relu && x < 0) x = '0;
    if (is_signed) begin
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (x > hi) x = hi;
      else if (x < lo) x = lo;
    end else begin
      hi = (64'sd1 <<< ow) - 64'sd1;
      lo = '0;
      if (x > hi) x = hi;
      else if (x < lo) x = lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/conv_window_mac.sv
// One KxK window dot product with a single register stage.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : window/weights are meaningful this cycle
//   window     : KxK pixels of the current window
//   weights    : KxK kernel
//   out_valid  : registered in_valid
//   sum        : registered full-precision sum (AW bits), held while idle
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  localparam int AW    = acc_width(DW, K, SIGNED)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [0:K-1][0:K-1][DW-1:0]     window,
  input  logic [0:K-1][0:K-1][DW-1:0]     weights,
  output logic                            out_valid,
  output logic [AW-1:0]                   sum
);

  logic                 valid_q, valid_d;
  logic [AW-1:0]        sum_q, sum_d;
  logic signed [AW-1:0] acc, pix_ext, wgt_ext;

  // Operands are widened to AW before multiplying; the exact sum fits in AW,
  // so arithmetic modulo 2^AW yields the exact result for both signednesses.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    valid_d = in_valid;
    sum_d   = sum_q;
    acc     = '0;
    pix_ext = '0;
    wgt_ext = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (SIGNED != 0) begin
          pix_ext = AW'(signed'(window[r][c]));
          wgt_ext = AW'(signed'(weights[r][c]));
        end else begin
          pix_ext = AW'(window[r][c]);
          wgt_ext = AW'(weights[r][c]);
        end
        acc = acc + pix_ext * wgt_ext;
      end
    end
    if (in_valid) sum_d = acc;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Valid-mode 2D convolution of an NxN image with a KxK kernel at stride S.
// One window is issued per cycle; each result is streamed and also written
// into the MxM result array, which holds until the next job overwrites it.
//   clk, rst     : clock, synchronous active-high reset (aborts a job)
//   start        : one-cycle request, accepted only in IDLE
//   relu_en      : clamp negative results to zero, captured with start
//   image_in     : NxN image, captured with start
//   weights      : KxK kernel, captured with start
//   busy         : job in progress
//   done         : one-cycle pulse after the last result is written
//   out_valid    : out_row/out_col/out_data carry a new result this cycle
//   out_row/col  : coordinates of out_data
//   out_data     : streamed result
//   conv_result  : full MxM result array
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int N      = 10,
  parameter int K      = 3,
  parameter int S      = 1,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int OW     = 16,
  localparam int M     = out_dim(N, K, S),
  localparam int AW    = acc_width(DW, K, SIGNED),
  localparam int CW    = $clog2(M) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            relu_en,
  input  logic [0:N-1][0:N-1][DW-1:0]     image_in,
  input  logic [0:K-1][0:K-1][DW-1:0]     weights,
  output logic                            busy,
  output logic                            done,
  output logic                            out_valid,
  output logic [CW-1:0]                   out_row,
  output logic [CW-1:0]                   out_col,
  output logic [OW-1:0]                   out_data,
  output logic [0:M-1][0:M-1][OW-1:0]     conv_result
);

  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int MIW = (M > 1) ? $clog2(M) : 1;

  conv_state_e                     state_q, state_d;
  logic [0:N-1][0:N-1][DW-1:0]     image_q, image_d;
  logic [0:K-1][0:K-1][DW-1:0]     weights_q, weights_d;
  logic                            relu_q, relu_d;
  logic [CW-1:0]                   i_q, i_d, j_q, j_d;
  logic [CW-1:0]                   iss_row_q, iss_row_d, iss_col_q, iss_col_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic                            out_valid_q, out_valid_d;
  logic [CW-1:0]                   out_row_q, out_row_d, out_col_q, out_col_d;
  logic [OW-1:0]                   out_data_q, out_data_d;
  logic [0:M-1][0:M-1][OW-1:0]     conv_result_q, conv_result_d;

  logic                            accept, issue, mac_valid;
  logic [0:K-1][0:K-1][DW-1:0]     window;
  logic [AW-1:0]                   mac_sum;
  logic signed [SAT_W-1:0]         sum_ext;
  logic [OW-1:0]                   result;

  // done is registered, so on its visible cycle the FSM is already in IDLE;
  // gating on done_q keeps a start coincident with done from being accepted.
  assign accept = (state_q == IDLE) && start && !done_q;
  assign issue  = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    image_d   = accept ? image_in : image_q;
    weights_d = accept ? weights  : weights_q;
    relu_d    = accept ? relu_en  : relu_q;
    unique case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        i_d     = '0;
        j_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        if (j_q == CW'(M - 1)) begin
          j_d = '0;
          if (i_q == CW'(M - 1)) begin
            i_d     = '0;
            state_d = DRAIN;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Both flags are registered one cycle behind the state, which lines busy
    // up with start acceptance and makes busy fall on the edge done rises.
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_comb begin
    window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window[r][c] = image_q[IW'(int'(i_q) * S + r)][IW'(int'(j_q) * S + c)];
      end
    end
  end

  conv_window_mac #(
    .K      (K),
    .DW     (DW),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .window    (window),
    .weights   (weights_q),
    .out_valid (mac_valid),
    .sum       (mac_sum)
  );

  always_comb begin
    if (SIGNED != 0) sum_ext = SAT_W'(signed'(mac_sum));
    else             sum_ext = SAT_W'(mac_sum);
    result = OW'(sat_relu(sum_ext, OW, SIGNED != 0, relu_q));

    // Coordinates travel alongside the MAC register so they stay aligned.
    iss_row_d = issue ? i_q : iss_row_q;
    iss_col_d = issue ? j_q : iss_col_q;

    out_valid_d   = mac_valid;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    out_data_d    = out_data_q;
    conv_result_d = conv_result_q;
    if (mac_valid) begin
      out_row_d  = iss_row_q;
      out_col_d  = iss_col_q;
      out_data_d = result;
      conv_result_d[MIW'(iss_row_q)][MIW'(iss_col_q)] = result;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the result array is a visible output with a defined post-reset
    // value, so it is cleared on reset like any control flop.
    if (rst) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      iss_row_q     <= '0;
      iss_col_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_data_q    <= '0;
      conv_result_q <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      iss_row_q     <= iss_row_d;
      iss_col_q     <= iss_col_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      out_valid_q   <= out_valid_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      out_data_q    <= out_data_d;
      conv_result_q <= conv_result_d;
    end
  end

  // Operand captures are always rewritten at start before they are read.
  always_ff @(posedge clk) begin
    image_q   <= image_d;
    weights_q <= weights_d;
    relu_q    <= relu_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_data    = out_data_q;
  assign conv_result = conv_result_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine: three configurations
// (defaults, stride 2 with OW=20, signed) share clock and reset.
module tb_conv2d_stream_engine;

  typedef struct {
    int     row;
    int     col;
    longint data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: defaults (N=10 K=3 S=1 DW=8 unsigned OW=16), M=8
  logic                      start0 = 1'b0, relu0 = 1'b0;
  logic [0:9][0:9][7:0]      img0 = '0;
  logic [0:2][0:2][7:0]      w0 = '0;
  logic                      busy0, done0, ov0;
  logic [3:0]                row0, col0;
  logic [15:0]               data0;
  logic [0:7][0:7][15:0]     res0;
  // Instance 1: S=2, OW=20, M=4
  logic                      start1 = 1'b0, relu1 = 1'b0;
  logic [0:9][0:9][7:0]      img1 = '0;
  logic [0:2][0:2][7:0]      w1 = '0;
  logic                      busy1, done1, ov1;
  logic [2:0]                row1, col1;
  logic [19:0]               data1;
  logic [0:3][0:3][19:0]     res1;
  // Instance 2: SIGNED=1, M=8
  logic                      start2 = 1'b0, relu2 = 1'b0;
  logic [0:9][0:9][7:0]      img2 = '0;
  logic [0:2][0:2][7:0]      w2 = '0;
  logic                      busy2, done2, ov2;
  logic [3:0]                row2, col2;
  logic [15:0]               data2;
  logic [0:7][0:7][15:0]     res2;

  conv2d_stream_engine u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .relu_en(relu0), .image_in(img0), .weights(w0),
    .busy(busy0), .done(done0), .out_valid(ov0), .out_row(row0), .out_col(col0),
    .out_data(data0), .conv_result(res0));

  conv2d_stream_engine #(.S(2), .OW(20)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .relu_en(relu1), .image_in(img1), .weights(w1),
    .busy(busy1), .done(done1), .out_valid(ov1), .out_row(row1), .out_col(col1),
    .out_data(data1), .conv_result(res1));

  conv2d_stream_engine #(.SIGNED(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .relu_en(relu2), .image_in(img2), .weights(w2),
    .busy(busy2), .done(done2), .out_valid(ov2), .out_row(row2), .out_col(col2),
    .out_data(data2), .conv_result(res2));

  int     n_checks = 0;
  int     n_errors = 0;
  int     beats[3];
  int     dones[3];
  exp_t   q0[$], q1[$], q2[$];
  int     mdl_img[10][10];
  int     mdl_ker[3][3];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: plain integer convolution, ReLU, clamp, mask.
  function automatic longint model_px(input int inst, input int r0, input int c0, input bit relu);
    longint acc = 0;
    longint hi;
    longint lo;
    int     ow  = (inst == 1) ? 20 : 16;
    bit     sgn = (inst == 2);
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        acc += longint'(mdl_img[r0 + kr][c0 + kc]) * longint'(mdl_ker[kr][kc]);
    if (relu && acc < 0) acc = 0;
    if (sgn) begin
      hi = (64'sd1 <<< (ow - 1)) - 1;
      lo = -hi - 1;
    end else begin
      hi = (64'sd1 <<< ow) - 1;
      lo = 0;
    end
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc & ((64'sd1 <<< ow) - 1);
  endfunction

  function automatic longint get_res(input int inst, input int i, input int j);
    case (inst)
      0:       return longint'(res0[i][j]);
      1:       return longint'(res1[i][j]);
      default: return longint'(res2[i][j]);
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction

  function automatic logic get_done(input int inst);
    case (inst) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction

  function automatic int get_qsize(input int inst);
    case (inst) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst) 0: start0 = v; 1: start1 = v; default: start2 = v; endcase
  endtask

  // 0 all ones; 1 ramp + centre kernel; 2 all 255; 3 ramp + ones kernel;
  // 4 image of 1 with kernel of -1 (signed instance)
  task automatic load_pattern(input int pat);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        case (pat)
          0, 4:    mdl_img[r][c] = 1;
          2:       mdl_img[r][c] = 255;
          default: mdl_img[r][c] = r * 10 + c;
        endcase
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        case (pat)
          1:       mdl_ker[r][c] = (r == 1 && c == 1) ? 1 : 0;
          2:       mdl_ker[r][c] = 255;
          4:       mdl_ker[r][c] = -1;
          default: mdl_ker[r][c] = 1;
        endcase
  endtask

  task automatic pack_inputs(input int inst, input bit relu);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        case (inst)
          0:       img0[r][c] = 8'(mdl_img[r][c]);
          1:       img1[r][c] = 8'(mdl_img[r][c]);
          default: img2[r][c] = 8'(mdl_img[r][c]);
        endcase
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        case (inst)
          0:       w0[r][c] = 8'(mdl_ker[r][c]);
          1:       w1[r][c] = 8'(mdl_ker[r][c]);
          default: w2[r][c] = 8'(mdl_ker[r][c]);
        endcase
    case (inst) 0: relu0 = relu; 1: relu1 = relu; default: relu2 = relu; endcase
  endtask

  task automatic sb_pop(input int inst, input longint row, input longint col, input longint data);
    exp_t e;
    int   sz = get_qsize(inst);
    check("sb_nonempty", longint'(sz > 0), 1);
    if (sz > 0) begin
      case (inst)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check("beat_row", row, longint'(e.row));
      check("beat_col", col, longint'(e.col));
      check("beat_data", data, e.data);
    end
    beats[inst]++;
  endtask

  always @(negedge clk) begin
    if (ov0) sb_pop(0, longint'(row0), longint'(col0), longint'(data0));
    if (ov1) sb_pop(1, longint'(row1), longint'(col1), longint'(data1));
    if (ov2) sb_pop(2, longint'(row2), longint'(col2), longint'(data2));
    if (done0) dones[0]++;
    if (done1) dones[1]++;
    if (done2) dones[2]++;
  end

  // mode 0: plain job; 1: extra starts mid-RUN and coincident with done;
  // 2: reset asserted once 20 beats have been seen
  task automatic run_job(input int inst, input bit relu, input int mode);
    int   m = (inst == 1) ? 4 : 8;
    int   s = (inst == 1) ? 2 : 1;
    int   cyc = 0, done_cyc = -1, dbase, bbase, nbad = 0;
    bit   got_done = 0, hit_rst = 0;
    exp_t e;
    pack_inputs(inst, relu);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < m; j++) begin
        e.row  = i;
        e.col  = j;
        e.data = model_px(inst, i * s, j * s, relu);
        case (inst) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
      end
    dbase = dones[inst];
    bbase = beats[inst];
    @(posedge clk); #1 set_start(inst, 1'b1);
    @(posedge clk); #1 set_start(inst, 1'b0);      // start sampled: edge 0
    check("busy_rise", longint'(get_busy(inst)), 1);
    while (!got_done && !hit_rst && cyc < m * m + 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (mode == 1 && cyc == 10) set_start(inst, 1'b1);
      if (mode == 1 && cyc == 11) set_start(inst, 1'b0);
      if (get_done(inst)) begin
        got_done = 1;
        done_cyc = cyc;
      end
      if (mode == 2 && beats[inst] - bbase >= 20) hit_rst = 1;
    end
    if (mode == 2) begin
      check("rst_reached", longint'(hit_rst), 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_out_valid", longint'(ov0), 0);
      check("rst_out_data", longint'(data0), 0);
      check("rst_busy", longint'(get_busy(inst)), 0);
      for (int i = 0; i < m; i++)
        for (int j = 0; j < m; j++)
          if (get_res(inst, i, j) != 0) nbad++;
      check("rst_array_nonzero", longint'(nbad), 0);
      case (inst) 0: q0.delete(); 1: q1.delete(); default: q2.delete(); endcase
      bbase = beats[inst];
      repeat (m * m + 10) @(posedge clk);
      #1;
      check("rst_no_beats", longint'(beats[inst] - bbase), 0);
      check("rst_no_done", longint'(dones[inst] - dbase), 0);
    end else begin
      check("done_seen", longint'(got_done), 1);
      check("done_cycle", longint'(done_cyc), longint'(m * m + 3));
      check("busy_fall", longint'(get_busy(inst)), 0);
      if (mode == 1) set_start(inst, 1'b1);
      @(posedge clk); #1;
      if (mode == 1) set_start(inst, 1'b0);
      check("done_pulse", longint'(get_done(inst)), 0);
      repeat (3) @(posedge clk);
      #1;
      check("busy_idle", longint'(get_busy(inst)), 0);
      check("beat_count", longint'(beats[inst] - bbase), longint'(m * m));
      check("queue_empty", longint'(get_qsize(inst)), 0);
      check("done_count", longint'(dones[inst] - dbase), 1);
      for (int i = 0; i < m; i++)
        for (int j = 0; j < m; j++)
          if (get_res(inst, i, j) != model_px(inst, i * s, j * s, relu)) nbad++;
      check("array_mismatches", longint'(nbad), 0);
    end
  endtask

  initial begin
    int nz = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", longint'(busy0), 0);
    check("reset_done", longint'(done0), 0);
    check("reset_out_valid", longint'(ov0), 0);
    check("reset_out_row", longint'(row0), 0);
    check("reset_out_col", longint'(col0), 0);
    check("reset_out_data", longint'(data0), 0);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (res0[i][j] != 16'd0) nz++;
    check("reset_array_nonzero", longint'(nz), 0);

    load_pattern(0); run_job(0, 1'b0, 0);
    check("ones_data", longint'(data0), 9);

    load_pattern(1); run_job(0, 1'b0, 0);
    check("centre_00", longint'(res0[0][0]), 11);
    check("centre_77", longint'(res0[7][7]), 88);

    load_pattern(2); run_job(0, 1'b0, 0);
    check("sat_ow16", longint'(res0[4][5]), 65535);
    run_job(1, 1'b0, 0);
    check("nosat_ow20", longint'(res1[2][1]), 585225);

    load_pattern(3); run_job(1, 1'b0, 0);
    check("s2_00", longint'(res1[0][0]), 99);
    check("s2_10", longint'(res1[1][0]), 279);
    check("s2_33", longint'(res1[3][3]), 693);

    load_pattern(4); run_job(2, 1'b1, 0);
    check("signed_relu", longint'(res2[3][3]), 0);
    run_job(2, 1'b0, 0);
    check("signed_neg9", longint'(res2[3][3]), longint'(16'hFFF7));

    load_pattern(0); run_job(0, 1'b0, 1);
    load_pattern(1); run_job(0, 1'b0, 2);
    run_job(0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
